add_sub: RTL and testbench



---
 rtl/add_sub.sv | 75 +++++++
 tb/tb_add_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/add_sub.sv
// Registered signed adder/subtractor with overflow and sticky overflow status.
// Latency 1 clock from in_valid to out_valid; no backpressure, accepts one input every clock.
module add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ov_clr,
  output logic [WIDTH-1:0] sum,
  output logic             ov,
  output logic             out_valid,
  output logic             ov_sticky
);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ov_q, ov_d;
  logic             out_valid_q, out_valid_d;
  logic             ov_sticky_q, ov_sticky_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             carry_in_msb;
  logic             carry_out_msb;
  logic             ov_calc;

  // One shared adder: subtraction is a + ~b with carry-in set by op.
  always_comb begin
    b_eff         = op ? ~b : b;
    full          = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
    carry_out_msb = full[WIDTH];
    carry_in_msb  = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ full[WIDTH-1];
    ov_calc       = carry_in_msb ^ carry_out_msb;
  end

  always_comb begin
    sum_d       = sum_q;
    ov_d        = ov_q;
    out_valid_d = in_valid;
    ov_sticky_d = ov_sticky_q;
    if (in_valid) begin
      sum_d = full[WIDTH-1:0];
      ov_d  = ov_calc;
    end
    // A new overflow takes priority over a clear on the same edge.
    if (in_valid && ov_calc) begin
      ov_sticky_d = 1'b1;
    end else if (ov_clr) begin
      ov_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
      ov_sticky_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ov_q        <= ov_d;
      out_valid_q <= out_valid_d;
      ov_sticky_q <= ov_sticky_d;
    end
  end

  assign sum       = sum_q;
  assign ov        = ov_q;
  assign out_valid = out_valid_q;
  assign ov_sticky = ov_sticky_q;

endmodule

// File: tb/tb_add_sub.sv
// Directed and exhaustive checks for add_sub at WIDTH=4.
module tb_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       ov_clr;
  logic [3:0] sum;
  logic       ov;
  logic       out_valid;
  logic       ov_sticky;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int a;
    int b;
    bit op;
    int sum;
    bit ov;
  } vec_t;

  vec_t vecs[10];

  add_sub #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .ov_clr    (ov_clr),
    .sum       (sum),
    .ov        (ov),
    .out_valid (out_valid),
    .ov_sticky (ov_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(input bit v, input bit o, input int ia, input int ib, input bit clr);
    @(negedge clk);
    in_valid = v;
    op       = o;
    a        = 4'(ia);
    b        = 4'(ib);
    ov_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic int ssum();
    return int'($signed(sum));
  endfunction

  initial begin
    vecs[0] = '{a:  7, b:  1, op: 1'b0, sum: -8, ov: 1'b1};
    vecs[1] = '{a: -8, b: -1, op: 1'b0, sum:  7, ov: 1'b1};
    vecs[2] = '{a:  3, b: -5, op: 1'b0, sum: -2, ov: 1'b0};
    vecs[3] = '{a:  7, b: -8, op: 1'b1, sum: -1, ov: 1'b1};
    vecs[4] = '{a: -8, b:  1, op: 1'b1, sum:  7, ov: 1'b1};
    vecs[5] = '{a:  0, b: -8, op: 1'b1, sum: -8, ov: 1'b1};
    vecs[6] = '{a:  3, b:  5, op: 1'b1, sum: -2, ov: 1'b0};
    vecs[7] = '{a: -8, b:  0, op: 1'b1, sum: -8, ov: 1'b0};
    vecs[8] = '{a: -8, b: -8, op: 1'b0, sum:  0, ov: 1'b1};
    vecs[9] = '{a: -8, b: -8, op: 1'b1, sum:  0, ov: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; ov_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", int'(sum), 0);
    chk("reset_ov", int'(ov), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sticky", int'(ov_sticky), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_out_valid", int'(out_valid), 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      chk($sformatf("vec%0d_sum", i), ssum(), vecs[i].sum);
      chk($sformatf("vec%0d_ov", i), int'(ov), int'(vecs[i].ov));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
    end

    // Exhaustive sweep against an integer model
    for (int o = 0; o < 2; o++) begin
      for (int ia = -8; ia < 8; ia++) begin
        for (int ib = -8; ib < 8; ib++) begin
          int r, es;
          bit eo;
          r  = (o != 0) ? ia - ib : ia + ib;
          eo = (r > 7) || (r < -8);
          es = (r > 7) ? r - 16 : ((r < -8) ? r + 16 : r);
          apply(1'b1, o[0], ia, ib, 1'b0);
          chk($sformatf("sweep_op%0d_a%0d_b%0d_sum", o, ia, ib), ssum(), es);
          chk($sformatf("sweep_op%0d_a%0d_b%0d_ov", o, ia, ib), int'(ov), int'(eo));
        end
      end
    end

    // Clear sticky left over from the sweep
    apply(1'b0, 1'b0, 0, 0, 1'b1);
    chk("clear_before_gating", int'(ov_sticky), 0);

    // Valid gating
    apply(1'b1, 1'b0, 2, 3, 1'b0);
    chk("gate_sum", ssum(), 5);
    chk("gate_out_valid", int'(out_valid), 1);
    chk("gate_ov", int'(ov), 0);
    apply(1'b0, 1'b1, 7, 7, 1'b0);
    chk("gate_hold_sum", ssum(), 5);
    chk("gate_hold_out_valid", int'(out_valid), 0);
    apply(1'b0, 1'b0, -8, -8, 1'b0);
    chk("gate_hold2_sum", ssum(), 5);
    chk("gate_hold2_ov", int'(ov), 0);
    chk("gate_hold2_out_valid", int'(out_valid), 0);

    // Sticky behaviour
    apply(1'b1, 1'b0, 7, 1, 1'b0);
    chk("sticky_set", int'(ov_sticky), 1);
    apply(1'b1, 1'b0, 1, 1, 1'b0);
    chk("sticky_hold_nonov_ov", int'(ov), 0);
    chk("sticky_hold_nonov", int'(ov_sticky), 1);
    apply(1'b0, 1'b0, 0, 0, 1'b0);
    chk("sticky_hold_idle", int'(ov_sticky), 1);
    apply(1'b0, 1'b0, 0, 0, 1'b1);
    chk("sticky_clear", int'(ov_sticky), 0);
    apply(1'b1, 1'b0, 7, 1, 1'b1);
    chk("sticky_set_wins", int'(ov_sticky), 1);
    apply(1'b1, 1'b0, 1, 1, 1'b1);
    chk("sticky_clear_with_nonov", int'(ov_sticky), 0);

    // Asynchronous reset between edges
    apply(1'b1, 1'b0, 7, 1, 1'b0);
    chk("pre_reset_ov", int'(ov), 1);
    chk("pre_reset_out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sum", int'(sum), 0);
    chk("async_ov", int'(ov), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_sticky", int'(ov_sticky), 0);
    @(negedge clk);
    in_valid = 1'b0;
    ov_clr   = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset_sum", int'(sum), 0);
    chk("after_reset_out_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
